pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer for the single-issue core data path.
- Holds the architectural PC and computes the next fetch address: sequential, conditional branch, JAL and JALR (bit 0 cleared).
- Adds what the first-generation PC block lacked:
  - configurable reset and trap vectors;
  - misaligned-target detection;
  - external trap entry with a saved exception PC (EPC) and cause;
  - trap return;
  - a halt state for a trap taken inside the handler.

Parameters:
- XLEN, 32, data and address width (must be ≥ 8).
- RESET_VEC, 32'h0000_0000, PC value after reset.
- TRAP_VEC, 32'h0000_0100, handler entry address (word-aligned).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- pc_en  input  1  advance enable; low = stall, all state held.
- pc_select  input  2  00 SEQ, 01 BRANCH, 10 JAL, 11 JALR.
- comparator  input  1  branch-taken flag (meaningful only for BRANCH).
- immgen_in  input  XLEN  sign-extended immediate.
- alu_in  input  XLEN  JALR target (rs1+imm).
- trap_req  input  1  external/illegal-instruction trap request.
- mret  input  1  return from trap handler.
- pc_value  output  XLEN  current PC.
- pc_plus4  output  XLEN  pc_value+4, combinational link value for JAL/JALR.
- epc  output  XLEN  saved trap PC.
- cause  output  2  00 none, 01 external trap, 10 misaligned target.
- misalign_fault  output  1  one-cycle registered pulse on misaligned redirect.
- halted  output  1  high in HALT state.

Behaviour:
- Reset (async):
  - pc_value = RESET_VEC; epc = 0; cause = 00; misalign_fault = 0; state = RUN; halted = 0.
- States:
  - RUN: normal execution.
  - TRAP: handler executing.
  - HALT: absorbing; exit only via reset.
- All updates occur on posedge clk only when pc_en = 1. With pc_en = 0, every register holds, and misalign_fault returns to 0 on the next clock edge.
- Target computation (internal, modulo 2^XLEN, wrap-around allowed, no overflow flag):
  - SEQ: pc+4.
  - BRANCH: comparator ? pc+imm : pc+4.
  - JAL: pc+imm.
  - JALR: alu_in with bit 0 forced to 0.
- Misaligned: target[1:0] ≠ 00 for a taken redirect (BRANCH taken, JAL, JALR after bit-0 clear). SEQ can never misalign.
- Priority per enabled cycle, highest first:
  1. HALT: hold everything.
  2. trap_req.
  3. Misaligned redirect.
  4. mret.
  5. Normal pc_select.
- Trap entry (trap_req or misaligned) in RUN:
  - epc <= pc_value (the faulting instruction's PC, not the target).
  - cause <= 01 or 10.
  - pc_value <= TRAP_VEC; state <= TRAP.
  - misalign_fault <= 1 only for cause 10.
  - trap_req with a simultaneously misaligned target records cause 01.
- Trap entry condition in TRAP: HALT; pc_value and epc held; halted <= 1; misalign_fault still pulses if applicable.
- mret in TRAP: pc_value <= epc; cause <= 00; state <= RUN.
- mret in RUN: ignored; treated as a normal pc_select advance.
- mret and trap_req together: trap wins.
- Normal advance in TRAP is identical to RUN.
- Latency: pc_value reflects the selection one cycle after the enabled edge. pc_plus4 follows pc_value combinationally.
- Reset asserted mid-trap or in HALT returns to RUN at RESET_VEC immediately (async).

Decomposition:
- Shared package core_pc_pkg holds:
  - pc_select encodings (SEQ/BRANCH/JAL/JALR);
  - cause encodings;
  - the state enum (RUN/TRAP/HALT).
- One natural sub-module: pc_target_calc. Combinational; outputs the next target and the misaligned flag from pc, pc_select, comparator, imm and alu_in.
- The sequencer itself holds the FSM and registers.

Test Plan:
- Reset then 3 enabled SEQ cycles -> pc_value 0x0, 0x4, 0x8, 0xC; pc_plus4 = 0x10.
- pc = 0x20, BRANCH, imm = -8: comparator = 1 -> 0x18; comparator = 0 -> 0x24. Stall via pc_en = 0 for 2 cycles -> pc unchanged.
- pc = 0x40, JALR, alu_in = 0x81 -> pc = 0x80, no fault. Then JAL, imm = 0x2 -> pc = TRAP_VEC 0x100, epc = 0x80, cause = 10, misalign_fault pulses exactly 1 cycle.
- pc = 0x30, trap_req = 1 with mret = 1 -> pc = 0x100, epc = 0x30, cause = 01. Two SEQ cycles -> 0x108. mret -> pc = 0x30, cause = 00, RUN.
- In TRAP, trap_req = 1 -> halted = 1, pc frozen across 5 enabled cycles. Async reset mid-cycle -> pc = RESET_VEC, halted = 0 without waiting for a clock.
- pc = 0xFFFF_FFFC SEQ -> 0x0 (wrap). XLEN = 16 build with RESET_VEC = 16'h0200 -> first pc 0x0200, SEQ gives 0x0204.

Source files
------------

// File: rtl/core_pc_pkg.sv
// Shared encodings for the program-counter sequencer: next-PC selects, trap causes and FSM states.
package core_pc_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_BRANCH = 2'b01,
    SEL_JAL    = 2'b10,
    SEL_JALR   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_EXT      = 2'b01,
    CAUSE_MISALIGN = 2'b10
  } cause_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_TRAP = 2'b01,
    ST_HALT = 2'b10
  } pc_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control and observation bundle between the core data path and the PC sequencer.
interface pc_sequencer_if #(
  parameter int XLEN = 32
);
  logic            pc_en;
  logic [1:0]      pc_select;
  logic            comparator;
  logic [XLEN-1:0] immgen_in;
  logic [XLEN-1:0] alu_in;
  logic            trap_req;
  logic            mret;
  logic [XLEN-1:0] pc_value;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] epc;
  logic [1:0]      cause;
  logic            misalign_fault;
  logic            halted;

  modport master (
    output pc_en, pc_select, comparator, immgen_in, alu_in, trap_req, mret,
    input  pc_value, pc_plus4, epc, cause, misalign_fault, halted
  );

  modport slave (
    input  pc_en, pc_select, comparator, immgen_in, alu_in, trap_req, mret,
    output pc_value, pc_plus4, epc, cause, misalign_fault, halted
  );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational next-fetch target and misalignment flag for the current PC.
module pc_target_calc
  import core_pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pc_select,
  input  logic            comparator,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_in,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic redirect;

  always_comb begin
    redirect = 1'b0;
    target   = pc + XLEN'(4);
    case (pc_sel_e'(pc_select))
      SEL_BRANCH: begin
        if (comparator) begin
          target   = pc + imm;
          redirect = 1'b1;
        end
      end
      SEL_JAL: begin
        target   = pc + imm;
        redirect = 1'b1;
      end
      SEL_JALR: begin
        target   = {alu_in[XLEN-1:1], 1'b0};
        redirect = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequential fetch is always word aligned, so only redirects can fault.
  assign misaligned = redirect && (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC register with trap entry/return and a halt state for nested traps.
//   state   | meaning
//   ST_RUN  | normal execution
//   ST_TRAP | trap handler executing, epc/cause valid
//   ST_HALT | trap taken inside handler; frozen until reset
module pc_sequencer
  import core_pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100)
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.slave  bus
);

  pc_state_e       state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] epc_q;
  cause_e          cause_q;
  logic            fault_q;
  logic            halted_q;
  logic [XLEN-1:0] target;
  logic            misaligned;

  pc_target_calc #(.XLEN(XLEN)) u_target (
    .pc         (pc_q),
    .pc_select  (bus.pc_select),
    .comparator (bus.comparator),
    .imm        (bus.immgen_in),
    .alu_in     (bus.alu_in),
    .target     (target),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_RUN;
      pc_q     <= RESET_VEC;
      epc_q    <= '0;
      cause_q  <= CAUSE_NONE;
      fault_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      if (bus.pc_en && state != ST_HALT) begin
        if (bus.trap_req || misaligned) begin
          // An external trap masks a coincident misaligned target.
          fault_q <= misaligned && !bus.trap_req;
          if (state == ST_TRAP) begin
            state    <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            epc_q   <= pc_q;
            cause_q <= bus.trap_req ? CAUSE_EXT : CAUSE_MISALIGN;
            pc_q    <= TRAP_VEC;
            state   <= ST_TRAP;
          end
        end else if (bus.mret && state == ST_TRAP) begin
          pc_q    <= epc_q;
          cause_q <= CAUSE_NONE;
          state   <= ST_RUN;
        end else begin
          pc_q <= target;
        end
      end
    end
  end

  assign bus.pc_value       = pc_q;
  assign bus.pc_plus4       = pc_q + XLEN'(4);
  assign bus.epc            = epc_q;
  assign bus.cause          = cause_q;
  assign bus.misalign_fault = fault_q;
  assign bus.halted         = halted_q;

endmodule
